alu_ctrl_seq: RTL and testbench

//  Registered, parametrised successor to the combinational ALU control decoder for the multi-cycle CPU.
//  - Decodes ALUop/funct into a CTL_W-bit ALU control code with a valid pulse.
//  - Adds slt/sltu/xor decodes.
//  - Sequences an iterative mult/div unit (start, DATA_W step cycles, done) with a ready/busy handshake.

---
 rtl/alu_ctrl_seq.sv | 115 +++++++++++
 tb/tb_alu_ctrl_seq.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control decoder that also sequences an iterative mult/div unit (optional abort via ALU_CTRL_ABORT_EN)
module alu_ctrl_seq #(
  parameter int DATA_W = 32,
  parameter int CTL_W = 4,
  parameter int CNT_W = $clog2(DATA_W) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [1:0]       alu_op_i,
  input  logic [5:0]       func_i,
`ifdef ALU_CTRL_ABORT_EN
  input  logic             abort_i,
  output logic             aborted_o,
`endif
  output logic             ready_o,
  output logic             busy_o,
  output logic [CTL_W-1:0] alu_ctl_o,
  output logic             ctl_valid_o,
  output logic             illegal_o,
  output logic             md_start_o,
  output logic             md_step_o,
  output logic             md_sign_o,
  output logic             md_div_o,
  output logic             done_o
);
  typedef enum logic [1:0] {IDLE, MD_START, MD_RUN, MD_DONE} state_t;
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CTL_W-1:0] r_alu_ctl;
  logic r_ctl_valid, r_illegal, r_sign, r_div;
  logic w_accept, w_md, w_abort;
  logic [3:0] w_code;
  assign w_md = alu_op_i == 2'b10 && func_i[5:2] == 4'b0110;
  assign w_accept = valid_i && r_state == IDLE;
`ifdef ALU_CTRL_ABORT_EN
  logic r_aborted;
  assign w_abort = abort_i && (r_state == MD_START || r_state == MD_RUN);
  assign aborted_o = r_aborted;
`else
  assign w_abort = 1'b0;
`endif
  always_comb begin
    w_code = 4'hF;
    case (alu_op_i)
      2'b00: w_code = 4'h2;
      2'b01: w_code = 4'h1;
      2'b11: w_code = 4'h6;
      default:
        case (func_i)
          6'b100000: w_code = 4'h0;
          6'b100010: w_code = 4'h1;
          6'b100001: w_code = 4'h2;
          6'b100100: w_code = 4'h3;
          6'b100101: w_code = 4'h4;
          6'b100111: w_code = 4'h5;
          6'b101010: w_code = 4'h6;
          6'b101011: w_code = 4'h7;
          6'b100110: w_code = 4'h8;
          default:   w_code = 4'hF;
        endcase
    endcase
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = w_accept && w_md ? MD_START : IDLE;
      MD_START: w_next = MD_RUN;
      MD_RUN:   w_next = r_cnt == CNT_W'(1) ? MD_DONE : MD_RUN;
      default:  w_next = IDLE;
    endcase
    if (w_abort) w_next = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_alu_ctl <= CTL_W'(4'hF);
      r_ctl_valid <= 1'b0;
      r_illegal <= 1'b0;
      r_sign <= 1'b0;
      r_div <= 1'b0;
`ifdef ALU_CTRL_ABORT_EN
      r_aborted <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      r_cnt <= r_state == MD_START ? CNT_W'(DATA_W) : r_state == MD_RUN ? r_cnt - 1'b1 : r_cnt;
      r_ctl_valid <= w_accept && !w_md;
      r_illegal <= w_accept && !w_md && w_code == 4'hF;
      if (w_accept && !w_md) r_alu_ctl <= CTL_W'(w_code);
      // funct bit0 selects unsigned, bit1 selects divide
      if (w_accept && w_md) begin
        r_sign <= ~func_i[0];
        r_div <= func_i[1];
      end else if (w_next == IDLE) begin
        r_sign <= 1'b0;
        r_div <= 1'b0;
      end
`ifdef ALU_CTRL_ABORT_EN
      r_aborted <= w_abort;
`endif
    end
  end
  assign ready_o = r_state == IDLE;
  assign busy_o = ~ready_o;
  assign alu_ctl_o = r_alu_ctl;
  assign ctl_valid_o = r_ctl_valid;
  assign illegal_o = r_illegal;
  assign md_start_o = r_state == MD_START;
  assign md_step_o = r_state == MD_RUN;
  assign md_sign_o = r_sign;
  assign md_div_o = r_div;
  assign done_o = r_state == MD_DONE;
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: directed bench with a timeline model of the decoder/mult-div sequencer
module tb_alu_ctrl_seq;
  localparam int DW = 32;
  logic clk = 0, rst_n = 0, valid_i = 0;
  logic [1:0] alu_op_i = 0;
  logic [5:0] func_i = 0;
  logic ready_o, busy_o, ctl_valid_o, illegal_o, md_start_o, md_step_o, md_sign_o, md_div_o, done_o;
  logic [3:0] alu_ctl_o;
`ifdef ALU_CTRL_ABORT_EN
  logic abort_i = 0, aborted_o;
`endif
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  alu_ctrl_seq #(.DATA_W(DW), .CTL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .alu_op_i(alu_op_i), .func_i(func_i),
`ifdef ALU_CTRL_ABORT_EN
    .abort_i(abort_i), .aborted_o(aborted_o),
`endif
    .ready_o(ready_o), .busy_o(busy_o), .alu_ctl_o(alu_ctl_o), .ctl_valid_o(ctl_valid_o),
    .illegal_o(illegal_o), .md_start_o(md_start_o), .md_step_o(md_step_o),
    .md_sign_o(md_sign_o), .md_div_o(md_div_o), .done_o(done_o));
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  function automatic logic [3:0] code(input logic [1:0] op, input logic [5:0] f);
    if (op != 2'b10) return op == 2'b00 ? 4'h2 : op == 2'b01 ? 4'h1 : 4'h6;
    case (f)
      6'b100000: return 4'h0;
      6'b100010: return 4'h1;
      6'b100001: return 4'h2;
      6'b100100: return 4'h3;
      6'b100101: return 4'h4;
      6'b100111: return 4'h5;
      6'b101010: return 4'h6;
      6'b101011: return 4'h7;
      6'b100110: return 4'h8;
      default:   return 4'hF;
    endcase
  endfunction
  // t = cycles elapsed since a mult/div accept (0 = idle): start at 1, steps 2..DW+1, done at DW+2
  int t;
  logic [3:0] m_ctl;
  logic m_v, m_ill, m_sign, m_div, m_ab;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t = 0; m_ctl = 4'hF; m_v = 0; m_ill = 0; m_sign = 0; m_div = 0; m_ab = 0;
    end else begin
      m_v = 0; m_ill = 0; m_ab = 0;
`ifdef ALU_CTRL_ABORT_EN
      if (abort_i && t >= 1 && t <= DW + 1) begin
        t = 0; m_ab = 1; m_sign = 0; m_div = 0;
      end else
`endif
      if (t != 0) begin
        t = t == DW + 2 ? 0 : t + 1;
        if (t == 0) begin m_sign = 0; m_div = 0; end
      end else if (valid_i) begin
        if (alu_op_i == 2'b10 && func_i inside {6'b011000, 6'b011001, 6'b011010, 6'b011011}) begin
          t = 1; m_sign = func_i inside {6'b011000, 6'b011010}; m_div = func_i inside {6'b011010, 6'b011011};
        end else begin
          m_v = 1; m_ctl = code(alu_op_i, func_i); m_ill = m_ctl == 4'hF;
        end
      end
    end
  end
  always @(negedge clk) begin
    chk("ready", ready_o, t == 0);
    chk("busy", busy_o, t != 0);
    chk("alu_ctl", alu_ctl_o, m_ctl);
    chk("ctl_valid", ctl_valid_o, m_v);
    chk("illegal", illegal_o, m_ill);
    chk("md_start", md_start_o, t == 1);
    chk("md_step", md_step_o, t >= 2 && t <= DW + 1);
    chk("done", done_o, t == DW + 2);
    chk("md_sign", md_sign_o, m_sign);
    chk("md_div", md_div_o, m_div);
`ifdef ALU_CTRL_ABORT_EN
    chk("aborted", aborted_o, m_ab);
`endif
  end
  task automatic req(input logic v, input logic [1:0] op, input logic [5:0] f);
    valid_i = v; alu_op_i = op; func_i = f;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("lit_reset_ctl", alu_ctl_o, 4'hF);
    chk("lit_reset_ready", ready_o, 1);
    rst_n = 1;
    req(1, 2'b00, 0);
    @(negedge clk) chk("lit_addu", {ctl_valid_o, alu_ctl_o}, 5'h12);
    req(1, 2'b01, 0);
    @(negedge clk) chk("lit_sub", {ctl_valid_o, alu_ctl_o}, 5'h11);
    req(1, 2'b11, 0);
    @(negedge clk) chk("lit_slt", {ctl_valid_o, alu_ctl_o}, 5'h16);
    req(1, 2'b10, 6'b100100);
    @(negedge clk) chk("lit_and", {ctl_valid_o, alu_ctl_o}, 5'h13);
    req(1, 2'b10, 6'b100111);
    @(negedge clk) chk("lit_nor", {ctl_valid_o, alu_ctl_o}, 5'h15);
    req(1, 2'b10, 6'b100110);
    @(negedge clk) chk("lit_xor", {ctl_valid_o, alu_ctl_o, ready_o}, 6'h31);
    req(1, 2'b10, 6'b111111);
    @(negedge clk) chk("lit_illegal", {illegal_o, ctl_valid_o, alu_ctl_o, busy_o}, 7'h7E);
    req(0, 2'b00, 0);
    @(negedge clk) chk("lit_pulse_end", {illegal_o, ctl_valid_o}, 0);
    req(1, 2'b10, 6'b011010);
    @(negedge clk) chk("lit_div_c1", {md_start_o, ready_o, md_div_o, md_sign_o}, 4'b1011);
    req(1, 2'b10, 6'b100000);
    for (int c = 2; c <= DW + 1; c++)
      @(negedge clk) chk("lit_div_step", {md_step_o, ctl_valid_o, ready_o, md_div_o, md_sign_o}, 5'b10011);
    @(negedge clk) chk("lit_div_done", {done_o, md_step_o, ready_o}, 3'b100);
    @(negedge clk) chk("lit_after_done", {ready_o, ctl_valid_o, md_div_o}, 3'b100);
    @(negedge clk) chk("lit_held_add", {ctl_valid_o, alu_ctl_o}, 5'h10);
    req(1, 2'b10, 6'b011001);
    @(negedge clk) chk("lit_multu", {md_start_o, md_sign_o, md_div_o}, 3'b100);
    req(0, 2'b00, 0);
    repeat (4) @(negedge clk);
    chk("lit_run", md_step_o, 1);
    #2 rst_n = 0;
    #1 chk("lit_async_rst", {busy_o, md_step_o, alu_ctl_o}, 6'h0F);
    @(negedge clk) rst_n = 1;
`ifdef ALU_CTRL_ABORT_EN
    req(1, 2'b10, 6'b011011);
    @(negedge clk) req(0, 2'b00, 0);
    repeat (5) @(negedge clk);
    chk("lit_step5", md_step_o, 1);
    abort_i = 1;
    @(negedge clk) chk("lit_aborted", {aborted_o, busy_o, md_step_o, done_o}, 4'b1000);
    abort_i = 0;
    repeat (DW + 4) @(negedge clk) chk("lit_no_done", done_o, 0);
`endif
    req(1, 2'b10, 6'b011000);
    @(negedge clk) req(0, 2'b00, 0);
    repeat (DW + 4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
